// File: rtl/datapath_seq_pkg.sv
// Shared types and constants for the datapath instruction sequencer.
// DATAPATH_SEQ_ILLEGAL_EN adds a sticky HALT state for undefined encodings.
package datapath_seq_pkg;

    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 13;
    localparam int unsigned OP_HI  = 12;
    localparam int unsigned OP_LO  = 11;
    localparam int unsigned RN_HI  = 10;
    localparam int unsigned RN_LO  = 8;
    localparam int unsigned RD_HI  = 7;
    localparam int unsigned RD_LO  = 5;
    localparam int unsigned SH_HI  = 4;
    localparam int unsigned SH_LO  = 3;
    localparam int unsigned RM_HI  = 2;
    localparam int unsigned RM_LO  = 0;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WR_IMM = 3'd2,
        S_GET_A  = 3'd3,
        S_GET_B  = 3'd4,
        S_EXEC   = 3'd5,
`ifdef DATAPATH_SEQ_ILLEGAL_EN
        S_WR_REG = 3'd6,
        S_HALT   = 3'd7
`else
        S_WR_REG = 3'd6
`endif
    } state_e;

    typedef enum logic [2:0] {
        K_UNDEF   = 3'd0,
        K_MOV_IMM = 3'd1,
        K_MOV_REG = 3'd2,
        K_ADD     = 3'd3,
        K_CMP     = 3'd4,
        K_AND     = 3'd5,
        K_MVN     = 3'd6
    } kind_e;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } ctrl_t;

    // Map opcode/op fields onto an instruction class; anything unlisted is undefined.
    function automatic kind_e classify(input logic [2:0] opc, input logic [1:0] op);
        kind_e k;
        k = K_UNDEF;
        if (opc == OPC_MOV) begin
            if (op == MOV_IMM)      k = K_MOV_IMM;
            else if (op == MOV_REG) k = K_MOV_REG;
        end else if (opc == OPC_ALU) begin
            case (op)
                OP_ADD:  k = K_ADD;
                OP_CMP:  k = K_CMP;
                OP_AND:  k = K_AND;
                default: k = K_MVN;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/datapath_seq_dec.sv
// Moore control decoder: maps sequencer state plus latched instruction onto
// the datapath control vector and the sign-extended immediate.
module datapath_seq_dec
    import datapath_seq_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned IMM_W = 8
) (
    input  state_e          state_i,
    input  logic [DW-1:0]   ir_i,
    output ctrl_t           ctrl_o,
    output logic [DW-1:0]   imm_o
);

    kind_e      kind;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [1:0] sh;
    logic [1:0] op;

    assign kind  = classify(ir_i[OPC_HI:OPC_LO], ir_i[OP_HI:OP_LO]);
    assign rn    = ir_i[RN_HI:RN_LO];
    assign rd    = ir_i[RD_HI:RD_LO];
    assign rm    = ir_i[RM_HI:RM_LO];
    assign sh    = ir_i[SH_HI:SH_LO];
    assign op    = ir_i[OP_HI:OP_LO];
    assign imm_o = {{(DW-IMM_W){ir_i[IMM_W-1]}}, ir_i[IMM_W-1:0]};

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_WAIT: ctrl_o.w = 1'b1;
            S_WR_IMM: begin
                ctrl_o.writenum = rn;
                ctrl_o.vsel     = 1'b1;
                ctrl_o.write    = 1'b1;
            end
            S_GET_A: begin
                ctrl_o.readnum = rn;
                ctrl_o.loada   = 1'b1;
            end
            S_GET_B: begin
                ctrl_o.readnum = rm;
                ctrl_o.loadb   = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.shift = sh;
                case (kind)
                    K_MOV_REG: begin
                        ctrl_o.asel  = 1'b1;
                        ctrl_o.aluop = ALU_ADD;
                        ctrl_o.loadc = 1'b1;
                    end
                    K_MVN: begin
                        ctrl_o.asel  = 1'b1;
                        ctrl_o.aluop = ALU_NOTB;
                        ctrl_o.loadc = 1'b1;
                    end
                    K_ADD, K_AND: begin
                        ctrl_o.aluop = op;
                        ctrl_o.loadc = 1'b1;
                    end
                    K_CMP: begin
                        ctrl_o.aluop = ALU_SUB;
                        ctrl_o.loads = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_WR_REG: begin
                ctrl_o.writenum = rd;
                ctrl_o.write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/datapath_seq.sv
// Instruction sequencer for the register-file/ALU datapath: one instruction per start.
// Define DATAPATH_SEQ_ILLEGAL_EN to add a sticky err output and HALT on undefined encodings.
module datapath_seq
    import datapath_seq_pkg::*;
#(
    parameter int unsigned IMM_W = 8,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic [DW-1:0] instr,
    output logic          w,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          write,
    output logic          vsel,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
`ifdef DATAPATH_SEQ_ILLEGAL_EN
    output logic          err,
`endif
    output logic [DW-1:0] imm_out
);

    state_e        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;
    kind_e         kind;
    ctrl_t         ctrl;

    assign kind = classify(ir_q[OPC_HI:OPC_LO], ir_q[OP_HI:OP_LO]);

`ifdef DATAPATH_SEQ_ILLEGAL_EN
    logic err_q, err_d;
    assign err = err_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
`ifdef DATAPATH_SEQ_ILLEGAL_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
`ifdef DATAPATH_SEQ_ILLEGAL_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
`ifdef DATAPATH_SEQ_ILLEGAL_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (kind)
                    K_MOV_IMM:               state_d = S_WR_IMM;
                    K_MOV_REG, K_MVN:        state_d = S_GET_B;
                    K_ADD, K_CMP, K_AND:     state_d = S_GET_A;
                    default: begin
`ifdef DATAPATH_SEQ_ILLEGAL_EN
                        err_d   = 1'b1;
                        state_d = S_HALT;
`else
                        state_d = S_WAIT;
`endif
                    end
                endcase
            end
            S_WR_IMM: state_d = S_WAIT;
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            // CMP only updates status, so it skips the register write-back.
            S_EXEC:   state_d = (kind == K_CMP) ? S_WAIT : S_WR_REG;
            S_WR_REG: state_d = S_WAIT;
`ifdef DATAPATH_SEQ_ILLEGAL_EN
            S_HALT:   state_d = S_HALT;
`endif
            default:  state_d = S_WAIT;
        endcase
    end

    datapath_seq_dec #(
        .DW    (DW),
        .IMM_W (IMM_W)
    ) u_dec (
        .state_i (state_q),
        .ir_i    (ir_q),
        .ctrl_o  (ctrl),
        .imm_o   (imm_out)
    );

    assign w        = ctrl.w;
    assign readnum  = ctrl.readnum;
    assign writenum = ctrl.writenum;
    assign write    = ctrl.write;
    assign vsel     = ctrl.vsel;
    assign loada    = ctrl.loada;
    assign loadb    = ctrl.loadb;
    assign loadc    = ctrl.loadc;
    assign loads    = ctrl.loads;
    assign asel     = ctrl.asel;
    assign bsel     = ctrl.bsel;
    assign shift    = ctrl.shift;
    assign ALUop    = ctrl.aluop;

endmodule
